// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one 64-bit memory port between instruction fetch and load/store.
// Define ARB_RR_EN for round-robin conflict resolution instead of data priority with a starvation override.
module imem_dmem_arbiter #(
   parameter int ADDR_WIDTH   = 10,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [63:0]           if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [63:0]           d_wdata,
   input  logic [7:0]            d_wstrb,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [63:0]           d_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [7:0]            mem_wstrb,
   output logic [63:0]           mem_wdata,
   input  logic [63:0]           mem_rdata
);
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
   owner_e own_q, own_d;
   logic   if_win;
`ifdef ARB_RR_EN
   logic last_d_q, last_d_d;
   always_comb if_win = !d_req || last_d_q;
   always_comb last_d_d = if_gnt ? 1'b0 : (d_gnt ? 1'b1 : last_d_q);
   always_ff @(posedge clk) last_d_q <= rst ? 1'b1 : last_d_d;
`else
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_q, starve_d;
   always_comb if_win = !d_req || starve_q == LIMIT;
   always_comb starve_d = (if_req && !if_gnt) ? ((starve_q == LIMIT) ? starve_q : starve_q + 4'd1) : 4'd0;
   always_ff @(posedge clk) starve_q <= rst ? 4'd0 : starve_d;
`endif
   always_comb if_gnt = !rst && if_req && if_win;
   always_comb d_gnt = !rst && d_req && !if_gnt;
   always_comb begin
      mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : '0);
      mem_re    = if_gnt || (d_gnt && !d_we);
      mem_we    = d_gnt && d_we;
      mem_wstrb = mem_we ? d_wstrb : 8'h00;
      mem_wdata = d_wdata;
      own_d     = if_gnt ? OWN_IF : ((d_gnt && !d_we) ? OWN_D : OWN_NONE);
   end
   always_ff @(posedge clk) own_q <= rst ? OWN_NONE : own_d;
   // a response owed from before reset is dropped while rst is high
   always_comb begin
      if_rvalid = !rst && own_q == OWN_IF;
      d_rvalid  = !rst && own_q == OWN_D;
      if_rdata  = if_rvalid ? mem_rdata : 64'h0;
      d_rdata   = d_rvalid ? mem_rdata : 64'h0;
   end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed and randomized checks of the arbiter against a memory and reference model.
module tb_imem_dmem_arbiter;
   localparam int AW    = 10;
   localparam int LIMIT = 4;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr = '0;
   logic [63:0]   if_rdata;
   logic          d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid;
   logic [AW-1:0] d_addr = '0;
   logic [63:0]   d_wdata = '0, d_rdata;
   logic [7:0]    d_wstrb = '0;
   logic [AW-1:0] mem_addr;
   logic          mem_re, mem_we;
   logic [7:0]    mem_wstrb;
   logic [63:0]   mem_wdata, mem_rdata;
   int            pass_cnt = 0, total = 0;
   logic [63:0]   mem_arr [1<<AW];
   logic [63:0]   ref_mem [1<<AW];
   int            m_starve = 0, m_own = 0;
   logic          m_last_d = 1'b1;
   logic [63:0]   m_data = '0;
   logic          e_if_gnt, e_d_gnt, e_re, e_we, e_if_rv, e_d_rv;
   logic [AW-1:0] e_addr;
   logic [7:0]    e_wstrb;
   logic [63:0]   e_if_rd, e_d_rd;

   always #5 clk = ~clk;

   imem_dmem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] strb);
      logic [63:0] r = old;
      for (int b = 0; b < 8; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [63:0] init_val(int i);
      if (i == 0) return 64'h1111111111111111;
      if (i == 1) return 64'hAAAAAAAAAAAAAAAA;
      if (i == 2) return 64'h2222222222222222;
      return {16'h5A5A, 16'(i), 16'hC3C3, ~16'(i)};
   endfunction

   // memory macro: one-cycle read latency, byte-masked writes
   always @(posedge clk) begin
      if (mem_we) mem_arr[mem_addr] <= merge(mem_arr[mem_addr], mem_wdata, mem_wstrb);
      if (mem_re) mem_rdata <= mem_arr[mem_addr];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   // expected outputs for the current inputs from the arbitration rules
   task calc();
      e_if_gnt = 1'b0;
      e_d_gnt  = 1'b0;
      e_if_rv  = 1'b0;
      e_d_rv   = 1'b0;
      if (!rst) begin
`ifdef ARB_RR_EN
         e_if_gnt = if_req && (!d_req || m_last_d);
`else
         e_if_gnt = if_req && (!d_req || m_starve >= LIMIT);
`endif
         e_d_gnt = d_req && !e_if_gnt;
         e_if_rv = m_own == 1;
         e_d_rv  = m_own == 2;
      end
      e_addr  = e_if_gnt ? if_addr : (e_d_gnt ? d_addr : '0);
      e_re    = e_if_gnt || (e_d_gnt && !d_we);
      e_we    = e_d_gnt && d_we;
      e_wstrb = e_we ? d_wstrb : 8'h00;
      e_if_rd = e_if_rv ? m_data : 64'h0;
      e_d_rd  = e_d_rv ? m_data : 64'h0;
   endtask

   task tick();
      calc();
      if (rst) begin
         m_starve = 0;
         m_last_d = 1'b1;
         m_own    = 0;
      end else begin
         m_starve = (if_req && !e_if_gnt) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
         if (e_if_gnt) m_last_d = 1'b0;
         else if (e_d_gnt) m_last_d = 1'b1;
         m_own = e_if_gnt ? 1 : (e_re ? 2 : 0);
         if (e_re) m_data = ref_mem[e_addr];
         if (e_we) ref_mem[e_addr] = merge(ref_mem[e_addr], d_wdata, d_wstrb);
      end
      @(posedge clk);
      #1;
   endtask

   task test_reset();
      rst = 1'b1; if_req = 1'b1; if_addr = 10'd3; d_req = 1'b0;
      #1;
      total++; if (if_gnt !== 1'b0 || mem_re !== 1'b0) $display("FAIL reset_gnt: if_gnt=%b mem_re=%b expected 0 0", if_gnt, mem_re); else pass_cnt++;
      total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0 || if_rdata !== 64'h0 || d_rdata !== 64'h0)
         $display("FAIL reset_rsp: if_rv=%b d_rv=%b if_rd=%h d_rd=%h expected zeros", if_rvalid, d_rvalid, if_rdata, d_rdata); else pass_cnt++;
      tick();
      tick();
      rst = 1'b0;
      #1;
      total++; if (if_gnt !== 1'b1 || mem_addr !== 10'd3 || mem_re !== 1'b1) $display("FAIL reset_release: if_gnt=%b mem_addr=%0d mem_re=%b expected 1 3 1", if_gnt, mem_addr, mem_re); else pass_cnt++;
      tick();
      if_req = 1'b0;
      #1;
      total++; if (if_rvalid !== 1'b1 || if_rdata !== init_val(3)) $display("FAIL reset_first_read: if_rv=%b if_rd=%h expected 1 %h", if_rvalid, if_rdata, init_val(3)); else pass_cnt++;
      tick();
   endtask

   task test_back_to_back();
      logic [63:0] exp [3];
      exp[0] = 64'h1111111111111111;
      exp[1] = 64'hAAAAAAAAAAAAAAAA;
      exp[2] = 64'h2222222222222222;
      if_req = 1'b1;
      for (int a = 0; a < 3; a++) begin
         if_addr = AW'(a);
         #1;
         total++; if (if_gnt !== 1'b1 || mem_addr !== AW'(a)) $display("FAIL b2b_gnt%0d: if_gnt=%b mem_addr=%0d expected 1 %0d", a, if_gnt, mem_addr, a); else pass_cnt++;
         if (a > 0) begin
            total++; if (if_rvalid !== 1'b1 || if_rdata !== exp[a-1]) $display("FAIL b2b_data%0d: if_rv=%b if_rd=%h expected 1 %h", a - 1, if_rvalid, if_rdata, exp[a-1]); else pass_cnt++;
         end
         tick();
      end
      if_req = 1'b0;
      #1;
      total++; if (if_rvalid !== 1'b1 || if_rdata !== exp[2] || d_rvalid !== 1'b0) $display("FAIL b2b_data2: if_rv=%b if_rd=%h d_rv=%b expected 1 %h 0", if_rvalid, if_rdata, d_rvalid, exp[2]); else pass_cnt++;
      tick();
   endtask

   task test_write_priority();
      logic [63:0] iv, want;
      iv   = init_val(5);
      want = {iv[63:32], 32'hCAFEF00D};
      if_req = 1'b1; if_addr = 10'd7;
      d_req = 1'b1; d_we = 1'b1; d_addr = 10'd5; d_wstrb = 8'h0F; d_wdata = 64'hDEADBEEF_CAFEF00D;
      #1;
      total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) $display("FAIL wr_gnt: d_gnt=%b if_gnt=%b expected 1 0", d_gnt, if_gnt); else pass_cnt++;
      total++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_wstrb !== 8'h0F || mem_addr !== 10'd5 || mem_wdata !== 64'hDEADBEEF_CAFEF00D)
         $display("FAIL wr_mem: we=%b re=%b strb=%h addr=%0d wdata=%h expected 1 0 0f 5 deadbeefcafef00d", mem_we, mem_re, mem_wstrb, mem_addr, mem_wdata); else pass_cnt++;
      tick();
      d_req = 1'b0;
      #1;
      total++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || if_gnt !== 1'b1 || mem_we !== 1'b0) $display("FAIL wr_after: d_rv=%b if_rv=%b if_gnt=%b mem_we=%b expected 0 0 1 0", d_rvalid, if_rvalid, if_gnt, mem_we); else pass_cnt++;
      tick();
      if_req = 1'b0; d_req = 1'b1; d_we = 1'b0;
      #1;
      total++; if (if_rvalid !== 1'b1 || if_rdata !== init_val(7) || d_gnt !== 1'b1) $display("FAIL wr_fetch_rsp: if_rv=%b if_rd=%h d_gnt=%b expected 1 %h 1", if_rvalid, if_rdata, d_gnt, init_val(7)); else pass_cnt++;
      tick();
      d_req = 1'b0;
      #1;
      total++; if (d_rvalid !== 1'b1 || d_rdata !== want || if_rdata !== 64'h0) $display("FAIL wr_readback: d_rv=%b d_rd=%h if_rd=%h expected 1 %h 0", d_rvalid, d_rdata, if_rdata, want); else pass_cnt++;
      tick();
   endtask

   task test_conflict();
      int n;
      logic prev_if, prev_d, want_if;
`ifdef ARB_RR_EN
      n = 6;
      rst = 1'b1;
      tick();
      rst = 1'b0;
`else
      n = 10;
      tick();
`endif
      prev_if = 1'b0; prev_d = 1'b0;
      if_req = 1'b1; if_addr = 10'd8; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
      for (int k = 0; k < n; k++) begin
`ifdef ARB_RR_EN
         want_if = (k % 2) == 0;
`else
         want_if = (k % (LIMIT + 1)) == LIMIT;
`endif
         #1;
         total++; if (if_gnt !== want_if || d_gnt !== !want_if) $display("FAIL conflict_gnt%0d: if_gnt=%b d_gnt=%b expected %b %b", k, if_gnt, d_gnt, want_if, !want_if); else pass_cnt++;
         if (k > 0) begin
            total++; if (if_rvalid !== prev_if || d_rvalid !== prev_d || (prev_if && if_rdata !== init_val(8)) || (prev_d && d_rdata !== init_val(9)))
               $display("FAIL conflict_rsp%0d: if_rv=%b d_rv=%b if_rd=%h d_rd=%h expected %b %b", k, if_rvalid, d_rvalid, if_rdata, d_rdata, prev_if, prev_d); else pass_cnt++;
         end
         prev_if = want_if; prev_d = !want_if;
         tick();
      end
      if_req = 1'b0; d_req = 1'b0;
      #1;
      total++; if (if_rvalid !== prev_if || d_rvalid !== prev_d) $display("FAIL conflict_tail: if_rv=%b d_rv=%b expected %b %b", if_rvalid, d_rvalid, prev_if, prev_d); else pass_cnt++;
      tick();
   endtask

   task test_reset_inflight();
      d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9; if_req = 1'b0;
      #1;
      total++; if (d_gnt !== 1'b1 || mem_re !== 1'b1) $display("FAIL inflight_gnt: d_gnt=%b mem_re=%b expected 1 1", d_gnt, mem_re); else pass_cnt++;
      tick();
      d_req = 1'b0; rst = 1'b1;
      #1;
      total++; if (d_rvalid !== 1'b0 || d_rdata !== 64'h0 || mem_re !== 1'b0) $display("FAIL inflight_rst: d_rv=%b d_rd=%h mem_re=%b expected 0 0 0", d_rvalid, d_rdata, mem_re); else pass_cnt++;
      tick();
      rst = 1'b0;
      #1;
      total++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || if_gnt !== 1'b0 || d_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0)
         $display("FAIL inflight_after: d_rv=%b if_rv=%b if_gnt=%b d_gnt=%b mem_we=%b mem_addr=%0d expected all 0", d_rvalid, if_rvalid, if_gnt, d_gnt, mem_we, mem_addr); else pass_cnt++;
      tick();
   endtask

   task test_random();
      for (int c = 0; c < 500; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         if (!if_req) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = AW'($urandom_range(0, 15));
         end
         if (!d_req) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = AW'($urandom_range(0, 15));
            d_wstrb = 8'($urandom);
            d_wdata = {$urandom, $urandom};
         end
         #1;
         calc();
         total++; if (if_gnt !== e_if_gnt || d_gnt !== e_d_gnt) $display("FAIL rnd_gnt c%0d: if_gnt=%b d_gnt=%b expected %b %b", c, if_gnt, d_gnt, e_if_gnt, e_d_gnt); else pass_cnt++;
         total++; if (mem_addr !== e_addr || mem_re !== e_re || mem_we !== e_we || mem_wstrb !== e_wstrb)
            $display("FAIL rnd_mem c%0d: addr=%0d re=%b we=%b strb=%h expected %0d %b %b %h", c, mem_addr, mem_re, mem_we, mem_wstrb, e_addr, e_re, e_we, e_wstrb); else pass_cnt++;
         total++; if (if_rvalid !== e_if_rv || if_rdata !== e_if_rd) $display("FAIL rnd_if_rsp c%0d: rv=%b rd=%h expected %b %h", c, if_rvalid, if_rdata, e_if_rv, e_if_rd); else pass_cnt++;
         total++; if (d_rvalid !== e_d_rv || d_rdata !== e_d_rd) $display("FAIL rnd_d_rsp c%0d: rv=%b rd=%h expected %b %h", c, d_rvalid, d_rdata, e_d_rv, e_d_rd); else pass_cnt++;
         tick();
         if (e_if_gnt) if_req = 1'b0;
         if (e_d_gnt) d_req = 1'b0;
      end
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
      tick();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         mem_arr[i] = init_val(i);
         ref_mem[i] = init_val(i);
      end
      test_reset();
      test_back_to_back();
      test_write_priority();
      test_conflict();
      test_reset_inflight();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares the single 64-bit-wide unified memory port between the instruction-fetch requester and the load/store requester.
- Sits between the fetch stage / LSU and the memory macro.
- Memory has fixed 1-cycle read latency: address and read-enable in cycle N, mem_rdata valid in N+1.
- The arbiter grants one requester per cycle, drives the memory, and routes read data back with a one-cycle valid pulse to the owner.

Parameters:
- ADDR_WIDTH, 10, doubleword address width (memory depth = 2**ADDR_WIDTH x 64 bits).
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (legal range 1..15).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch read request
if_addr  in  ADDR_WIDTH  fetch doubleword address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  64  fetch read data
d_req  in  1  data request
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_WIDTH  data doubleword address
d_wdata  in  64  write data
d_wstrb  in  8  byte write strobes, bit i enables byte i
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data read data valid
d_rdata  out  64  data read data
mem_addr  out  ADDR_WIDTH  memory address
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_wstrb  out  8  memory byte strobes
mem_wdata  out  64  memory write data
mem_rdata  in  64  memory read data, 1 cycle after mem_re

Behaviour:
- Grant logic:
  - Grants are combinational from the current requests and registered state.
  - At most one of if_gnt/d_gnt is high per cycle; a grant is only given to an asserted request.
  - Requesters hold req/addr/data stable until they see gnt.
- Default priority: data over fetch.
  - starve_cnt (4 bits) increments each cycle if_req=1 and if_gnt=0.
  - It clears when if_gnt=1 or if_req=0.
  - When starve_cnt == STARVE_LIMIT and both request, fetch wins that cycle.
- Memory drive:
  - Granted requester drives mem_addr.
  - mem_re = grant of a read (fetch is always a read; data when d_we=0).
  - mem_we = d_gnt & d_we; mem_wstrb = d_wstrb when mem_we, else 0.
  - mem_wdata = d_wdata.
  - With no grant: mem_addr=0, mem_re=0, mem_we=0.
- Response routing:
  - Registered rsp_owner (NONE/IF/D) captures the owner of each granted read.
  - In the next cycle, the matching rvalid = 1 for exactly one cycle and its rdata = mem_rdata.
  - The non-owner's rdata = 0.
  - Writes produce no rvalid.
  - Throughput: one access per cycle; back-to-back reads from either side are allowed.
- Simultaneous events:
  - A read response for cycle N and a new grant in cycle N+1 coexist; the response uses registered owner, the grant uses current requests.
- Reset:
  - if_gnt, d_gnt, if_rvalid, d_rvalid, mem_re, mem_we = 0; rdata outputs = 0.
  - starve_cnt = 0; rsp_owner = NONE.
  - Reset asserted with a read in flight discards that response; no rvalid in the cycle after reset.
- Width rules:
  - starve_cnt saturates at STARVE_LIMIT; no wrap.
  - Addresses pass unmodified; no byte-swap here (fetch stage owns instruction byte order).

Optional Feature:
- ARB_RR_EN defined: the starvation counter is removed. When both request, grant alternates using a 1-bit last_winner register (reset = data, so fetch wins the first conflict). A single requester always wins.
- ARB_RR_EN undefined: fixed data priority with STARVE_LIMIT override, as above.

Test Plan:
- Reset with if_req=1 -> if_gnt=0, mem_re=0 during rst; first cycle after release: if_gnt=1, mem_addr=if_addr; next cycle if_rvalid=1, if_rdata=mem_rdata.
- if_req only, if_addr 0,1,2 on consecutive cycles -> if_gnt every cycle, if_rvalid on each following cycle, data 0x1111111111111111, 0xAAAAAAAAAAAAAAAA, 0x2222222222222222 in order.
- d_req write, d_addr=5, d_wstrb=0x0F, d_wdata=0xDEADBEEF_CAFEF00D, with if_req=1 -> d_gnt=1, if_gnt=0, mem_we=1, mem_wstrb=0x0F; no rvalid next cycle; fetch granted when d_req drops.
- Both request continuously, STARVE_LIMIT=4, default build -> data wins 4 cycles, fetch wins cycle 5, pattern repeats; never two grants in one cycle.
- Data read granted, rst asserted the following cycle -> d_rvalid=0 in that and later cycles; outputs at reset values.
- ARB_RR_EN build, both requesting for 6 cycles -> grants IF,D,IF,D,IF,D; rvalid routes to the matching owner each following cycle.
